// File: rtl/cpu6502_pkg.sv
// cpu6502_pkg: shared types and constants for the 6502 branch sequencer.
package cpu6502_pkg;
    typedef enum logic [1:0] {IDLE, FETCH_OFF, ADD_LO, FIX_HI} state_t;
    localparam logic [1:0] SEL_N = 2'd0;
    localparam logic [1:0] SEL_V = 2'd1;
    localparam logic [1:0] SEL_C = 2'd2;
    localparam logic [1:0] SEL_Z = 2'd3;
    localparam logic [7:0] BRANCH_MASK  = 8'h1F;
    localparam logic [7:0] BRANCH_MATCH = 8'h10;
    function automatic logic is_branch(input logic [7:0] op);
        return (op & BRANCH_MASK) == BRANCH_MATCH;
    endfunction
endpackage

// File: rtl/branch_cond_eval.sv
// branch_cond_eval: selects the flag named by opcode[7:6] and compares it with opcode[5].
module branch_cond_eval
    import cpu6502_pkg::*;
(
    input  logic [7:0] opcode,
    input  logic       flag_n,
    input  logic       flag_v,
    input  logic       flag_c,
    input  logic       flag_z,
    output logic       cond
);
    logic flag;
    always_comb begin
        flag = opcode[7:6] == SEL_N ? flag_n :
               opcode[7:6] == SEL_V ? flag_v :
               opcode[7:6] == SEL_C ? flag_c : flag_z;
        cond = flag == opcode[5];
    end
endmodule

// File: rtl/branch_sequencer.sv
// branch_sequencer: multi-cycle 6502 relative-branch controller driving PC updates
// with 2/3/4-cycle timing (not taken / taken same page / taken page cross).
module branch_sequencer
    import cpu6502_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] opcode,
    input  logic       flag_n,
    input  logic       flag_v,
    input  logic       flag_c,
    input  logic       flag_z,
    input  logic [7:0] data_read,
    input  logic [7:0] pcl,
    input  logic [7:0] pch,
    output logic       pc_inc,
    output logic       pcl_load,
    output logic       pch_load,
    output logic [7:0] pcl_new,
    output logic [7:0] pch_new,
    output logic       busy,
    output logic       taken,
    output logic       done
);
    state_t     state_q, state_d;
    logic [7:0] opcode_q, opcode_d;
    logic [7:0] offset_q, offset_d;
    logic       taken_q, taken_d;
    logic       cond;
    logic [8:0] sum9;

    branch_cond_eval u_cond (
        .opcode (opcode_q),
        .flag_n (flag_n),
        .flag_v (flag_v),
        .flag_c (flag_c),
        .flag_z (flag_z),
        .cond   (cond)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            opcode_q <= '0;
            offset_q <= '0;
            taken_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            offset_q <= offset_d;
            taken_q  <= taken_d;
        end
    end

    // A page cross happens when the unsigned carry disagrees with the offset sign;
    // offset_q[7] then also tells FIX_HI which way to move PCH.
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        offset_d = offset_q;
        taken_d  = taken_q;
        pc_inc   = 1'b0;
        pcl_load = 1'b0;
        pch_load = 1'b0;
        pcl_new  = 8'h00;
        pch_new  = 8'h00;
        done     = 1'b0;
        sum9     = {1'b0, pcl} + {1'b0, offset_q};
        case (state_q)
            IDLE: begin
                if (start && is_branch(opcode)) begin
                    state_d  = FETCH_OFF;
                    opcode_d = opcode;
                end
            end
            FETCH_OFF: begin
                pc_inc   = 1'b1;
                offset_d = data_read;
                taken_d  = cond;
                done     = !cond;
                state_d  = cond ? ADD_LO : IDLE;
            end
            ADD_LO: begin
                pcl_load = 1'b1;
                pcl_new  = sum9[7:0];
                done     = !(sum9[8] ^ offset_q[7]);
                state_d  = (sum9[8] ^ offset_q[7]) ? FIX_HI : IDLE;
            end
            FIX_HI: begin
                pch_load = 1'b1;
                pch_new  = offset_q[7] ? pch - 8'd1 : pch + 8'd1;
                done     = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy  = state_q != IDLE;
    assign taken = taken_q;
endmodule

// File: tb/tb_branch_sequencer.sv
// tb_branch_sequencer: directed plus randomized branches checked against a
// 16-bit target-address model of 6502 branch timing.
module tb_branch_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] opcode = 8'h00;
    logic       flag_n = 1'b0, flag_v = 1'b0, flag_c = 1'b0, flag_z = 1'b0;
    logic [7:0] data_read = 8'h00, pcl = 8'h00, pch = 8'h00;
    logic       pc_inc, pcl_load, pch_load, busy, taken, done;
    logic [7:0] pcl_new, pch_new;
    int         n_chk = 0, n_pass = 0;

    branch_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode),
        .flag_n(flag_n), .flag_v(flag_v), .flag_c(flag_c), .flag_z(flag_z),
        .data_read(data_read), .pcl(pcl), .pch(pch),
        .pc_inc(pc_inc), .pcl_load(pcl_load), .pch_load(pch_load),
        .pcl_new(pcl_new), .pch_new(pch_new),
        .busy(busy), .taken(taken), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic set_flags(input logic [3:0] nvcz);
        {flag_n, flag_v, flag_c, flag_z} = nvcz;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after done,
    // which is the first cycle a new start may be issued.
    task automatic run(input logic [7:0] op, input logic [3:0] nvcz, input logic [15:0] pc,
                       input logic [7:0] off, input bit junk);
        logic [15:0] target;
        logic        exp_taken;
        int          exp_cyc;
        exp_taken = nvcz[3 - op[7:6]] == op[5];
        target    = pc + {{8{off[7]}}, off};
        exp_cyc   = !exp_taken ? 2 : (target[15:8] == pc[15:8] ? 3 : 4);
        start = 1'b1; opcode = op; set_flags(nvcz);
        data_read = off; pcl = pc[7:0]; pch = pc[15:8];
        for (int k = 2; k <= exp_cyc; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (k > 2) begin
                set_flags(4'($urandom));
                data_read = 8'($urandom);
            end
            @(negedge clk);
            chk($sformatf("ctl op=%h k=%0d", op, k), {busy, done, pc_inc, pcl_load, pch_load},
                {1'b1, k == exp_cyc, k == 2, k == 3, k == 4});
            chk($sformatf("pcl_new op=%h k=%0d", op, k), pcl_new, k == 3 ? target[7:0] : 8'h00);
            chk($sformatf("pch_new op=%h k=%0d", op, k), pch_new, k == 4 ? target[15:8] : 8'h00);
            if (k > 2) chk("taken_mid", taken, 1'b1);
            if (junk) begin
                start  = 1'b1;
                opcode = {3'($urandom), 5'b10000};
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk($sformatf("idle op=%h", op), {busy, pc_inc, pcl_load, pch_load}, 4'b0000);
        chk($sformatf("taken op=%h", op), taken, exp_taken);
    endtask

    initial begin
        #1;
        chk("reset_outs", {busy, taken, done, pc_inc, pcl_load, pch_load, pcl_new, pch_new}, 22'd0);
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        run(8'hF0, 4'b0000, 16'h1234, 8'h05, 1'b0);
        run(8'hD0, 4'b0000, 16'h0310, 8'h10, 1'b0);
        run(8'hB0, 4'b0010, 16'h03F0, 8'h20, 1'b0);
        run(8'h30, 4'b1000, 16'h0305, 8'hF0, 1'b0);
        run(8'h30, 4'b1000, 16'h0005, 8'hF0, 1'b0);
        run(8'h10, 4'b0000, 16'hFFF0, 8'h20, 1'b1);
        // Abort in ADD_LO
        start = 1'b1; opcode = 8'h70; set_flags(4'b0100);
        data_read = 8'h05; pcl = 8'h10; pch = 8'h03;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("pre_reset_add_lo", pcl_load, 1'b1);
        reset = 1'b1; #1;
        chk("async_reset_outs", {busy, taken, done, pc_inc, pcl_load, pch_load, pcl_new, pch_new}, 22'd0);
        #1 reset = 1'b0;
        @(negedge clk);
        run(8'h70, 4'b0100, 16'h0310, 8'h05, 1'b0);
        // Non-branch opcode
        start = 1'b1; opcode = 8'hA9;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("nonbranch_ignored", busy, 1'b0);
        run(8'h90, 4'b0000, 16'h80FF, 8'h01, 1'b1);
        for (int i = 0; i < 60; i++)
            run({3'($urandom), 5'b10000}, 4'($urandom), 16'($urandom), 8'($urandom), 1'($urandom));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end expected summary");
        $fatal(1);
    end
endmodule
